// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes and flag bit positions for the conditional-execution unit
package cond_pkg;

  localparam logic [3:0] COND_AL_CODE = 4'b1110;
  localparam logic [3:0] COND_NV_CODE = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = COND_AL_CODE,
    COND_NV = COND_NV_CODE
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition evaluation against NZCV
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      // NV is defined as never-execute rather than left unpredictable
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_it_unit.sv
// rtl/cond_it_unit.sv - NZCV flag register, condition gating and IT-block predication
module cond_it_unit
  import cond_pkg::*;
#(
  parameter int IT_DEPTH = 4,
  parameter int NCTRL    = 4,
  localparam int LW      = $clog2(IT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [1:0]          FlagW,
  input  logic [NCTRL-1:0]    CtrlIn,
  input  logic                it_start,
  input  logic [3:0]          it_cond,
  input  logic [IT_DEPTH-1:0] it_mask,
  input  logic [LW-1:0]       it_len,
  output logic [NCTRL-1:0]    CtrlOut,
  output logic                CondEx,
  output logic [3:0]          Flags,
  output logic                in_it,
  output logic [LW-1:0]       it_remaining,
  output logic                it_err
);

  logic [3:0]          flags_q;
  logic [3:0]          it_cond_q;
  logic [IT_DEPTH-1:0] mask_q;
  logic [LW-1:0]       count_q;

  logic [3:0] eff_cond;
  logic       len_ok;
  logic       it_try;
  logic       it_reject;
  logic       it_accept;

  assign in_it        = (count_q != '0);
  assign it_remaining = count_q;
  assign Flags        = flags_q;

  // Inside a block the decoder's Cond is ignored; the mask bit picks then/else
  assign eff_cond = in_it ? (mask_q[0] ? it_cond_q : (it_cond_q ^ 4'b0001)) : Cond;

  cond_eval u_cond_eval (
    .cond    (eff_cond),
    .flags   (flags_q),
    .cond_ex (CondEx)
  );

  assign len_ok    = (it_len != '0) && (it_len <= LW'(IT_DEPTH));
  assign it_try    = en & it_start & ~flush;
  assign it_reject = it_try & (in_it | ~len_ok);
  assign it_accept = it_try & CondEx & ~in_it & len_ok;

  assign it_err  = reset & it_reject;
  assign CtrlOut = reset ? (CtrlIn & {NCTRL{CondEx & en & ~it_reject}}) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (en & FlagW[1] & CondEx) begin
        flags_q[FLAG_N] <= ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (en & FlagW[0] & CondEx) begin
        flags_q[FLAG_C] <= ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // Advance happens on every en cycle in a block, executed or not, including nested rejects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      it_cond_q <= 4'b0000;
      mask_q    <= '0;
      count_q   <= '0;
    end else if (flush) begin
      mask_q  <= '0;
      count_q <= '0;
    end else if (en & in_it) begin
      mask_q  <= mask_q >> 1;
      count_q <= count_q - LW'(1);
    end else if (it_accept) begin
      it_cond_q <= it_cond;
      mask_q    <= it_mask;
      count_q   <= it_len;
    end
  end

endmodule

// File: tb/tb_cond_it_unit.sv
// tb/tb_cond_it_unit.sv - table-driven scoreboard bench for cond_it_unit
module tb_cond_it_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] Cond = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic [3:0] CtrlIn = 4'h0;
  logic       it_start = 1'b0;
  logic [3:0] it_cond = 4'h0;
  logic [3:0] it_mask = 4'h0;
  logic [2:0] it_len = 3'd0;
  logic [3:0] CtrlOut;
  logic       CondEx;
  logic [3:0] Flags;
  logic       in_it;
  logic [2:0] it_remaining;
  logic       it_err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] ctrl;
    logic       cx;
    logic [3:0] flags;
    logic       init;
    logic [2:0] rem;
    logic       err;
  } exp_t;

  typedef struct {
    logic       en, fl, its;
    logic [3:0] cond, alu, ctrl, itc, itm;
    logic [1:0] fw;
    logic [2:0] itl;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  cond_it_unit #(.IT_DEPTH(4), .NCTRL(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .Cond         (Cond),
    .ALUFlags     (ALUFlags),
    .FlagW        (FlagW),
    .CtrlIn       (CtrlIn),
    .it_start     (it_start),
    .it_cond      (it_cond),
    .it_mask      (it_mask),
    .it_len       (it_len),
    .CtrlOut      (CtrlOut),
    .CondEx       (CondEx),
    .Flags        (Flags),
    .in_it        (in_it),
    .it_remaining (it_remaining),
    .it_err       (it_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic vec_t mk(input logic e, input logic f, input logic [3:0] c,
                              input logic [3:0] a, input logic [1:0] w, input logic [3:0] k,
                              input logic s, input logic [3:0] ic, input logic [3:0] im,
                              input logic [2:0] il, input logic [3:0] xk, input logic xc,
                              input logic [3:0] xf, input logic xi, input logic [2:0] xr,
                              input logic xe);
    vec_t r;
    r.en = e; r.fl = f; r.cond = c; r.alu = a; r.fw = w; r.ctrl = k;
    r.its = s; r.itc = ic; r.itm = im; r.itl = il;
    r.e.ctrl = xk; r.e.cx = xc; r.e.flags = xf; r.e.init = xi; r.e.rem = xr; r.e.err = xe;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s row %0d: got %h want %h", nm, row, got, want);
  endtask

  task automatic compare_out(input int row);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL scoreboard row %0d: got empty queue want entry", row);
      return;
    end
    e = exp_q.pop_front();
    chk("ctrlout", row, 8'(CtrlOut), 8'(e.ctrl));
    chk("condex", row, 8'(CondEx), 8'(e.cx));
    chk("flags", row, 8'(Flags), 8'(e.flags));
    chk("in_it", row, 8'(in_it), 8'(e.init));
    chk("it_remaining", row, 8'(it_remaining), 8'(e.rem));
    chk("it_err", row, 8'(it_err), 8'(e.err));
  endtask

  task automatic apply(input vec_t v, input int row);
    @(posedge clk);
    #1;
    en = v.en; flush = v.fl; Cond = v.cond; ALUFlags = v.alu; FlagW = v.fw;
    CtrlIn = v.ctrl; it_start = v.its; it_cond = v.itc; it_mask = v.itm; it_len = v.itl;
    exp_q.push_back(v.e);
    @(negedge clk);
    compare_out(row);
  endtask

  initial begin
    exp_t e;
    //          en fl cond alu fw ctrl its itc itm itl | ctrl cx flags in rem err
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h0,0,3'd0,0)); // 1
    tbl.push_back(mk(1,0,4'h0,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h0,0,3'd0,0)); // 2 EQ, Z=0
    tbl.push_back(mk(1,0,4'hE,4'h4,2'b11,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h0,0,3'd0,0)); // 3 write Z
    tbl.push_back(mk(1,0,4'h0,4'h0,2'b00,4'hA,0,4'h0,4'h0,3'd0, 4'hA,1,4'h4,0,3'd0,0)); // 4 EQ now true
    tbl.push_back(mk(1,0,4'hE,4'hB,2'b01,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h4,0,3'd0,0)); // 5 write CV
    tbl.push_back(mk(1,0,4'h1,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,0,3'd0,0)); // 6 NE false
    tbl.push_back(mk(1,0,4'h1,4'h0,2'b11,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,0,3'd0,0)); // 7 gated write
    tbl.push_back(mk(1,0,4'hD,4'h0,2'b00,4'h6,0,4'h0,4'h0,3'd0, 4'h6,1,4'h7,0,3'd0,0)); // 8 LE
    tbl.push_back(mk(1,0,4'hF,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,0,3'd0,0)); // 9 NV
    tbl.push_back(mk(1,0,4'h2,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 10 CS
    tbl.push_back(mk(1,0,4'h8,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,0,3'd0,0)); // 11 HI
    tbl.push_back(mk(1,0,4'hB,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 12 LT
    tbl.push_back(mk(0,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,1,4'h7,0,3'd0,0)); // 13 stall
    // IT EQ mask 0101 len 3, with a two-cycle stall after the first instruction
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'h5,3'd3, 4'hF,1,4'h7,0,3'd0,0)); // 14
    tbl.push_back(mk(1,0,4'hF,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,1,3'd3,0)); // 15
    tbl.push_back(mk(0,0,4'hF,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,1,3'd2,0)); // 16
    tbl.push_back(mk(0,0,4'hF,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,1,3'd2,0)); // 17
    tbl.push_back(mk(1,0,4'hF,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,1,3'd2,0)); // 18
    tbl.push_back(mk(1,0,4'hF,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,1,3'd1,0)); // 19
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 20
    // nesting, then stall on the last instruction
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd2, 4'hF,1,4'h7,0,3'd0,0)); // 21
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd2, 4'h0,1,4'h7,1,3'd2,1)); // 22
    tbl.push_back(mk(0,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,1,4'h7,1,3'd1,0)); // 23
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,1,3'd1,0)); // 24
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 25
    // illegal lengths
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd0, 4'h0,1,4'h7,0,3'd0,1)); // 26
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd5, 4'h0,1,4'h7,0,3'd0,1)); // 27
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 28
    // IT whose own condition fails does not start a block
    tbl.push_back(mk(1,0,4'h1,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd2, 4'h0,0,4'h7,0,3'd0,0)); // 29
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 30
    // flush with it_start
    tbl.push_back(mk(1,1,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd2, 4'hF,1,4'h7,0,3'd0,0)); // 31
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 32
    // AL-based block, else slots become NV; flush at remaining=2
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'hE,4'hA,3'd4, 4'hF,1,4'h7,0,3'd0,0)); // 33
    tbl.push_back(mk(1,0,4'h0,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,1,3'd4,0)); // 34
    tbl.push_back(mk(1,0,4'h0,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,1,3'd3,0)); // 35
    tbl.push_back(mk(1,1,4'h0,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h7,1,3'd2,0)); // 36
    tbl.push_back(mk(1,0,4'h0,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,0,3'd0,0)); // 37
    // block to be abandoned by reset
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,1,4'h0,4'hF,3'd3, 4'hF,1,4'h7,0,3'd0,0)); // 38
    tbl.push_back(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'hF,1,4'h7,1,3'd3,0)); // 39

    // reset held: strobes forced low, state at reset values
    apply(mk(1,0,4'hE,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,1,4'h0,0,3'd0,0), 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

    // asynchronous reset mid-block, sampled between clock edges
    @(posedge clk);
    #1;
    en = 1'b1; flush = 1'b0; Cond = 4'hE; FlagW = 2'b00; CtrlIn = 4'hF; it_start = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    e.ctrl = 4'h0; e.cx = 1'b1; e.flags = 4'h0; e.init = 1'b0; e.rem = 3'd0; e.err = 1'b0;
    exp_q.push_back(e);
    compare_out(100);
    @(negedge clk);
    reset = 1'b1;

    apply(mk(1,0,4'h0,4'h0,2'b00,4'hF,0,4'h0,4'h0,3'd0, 4'h0,0,4'h0,0,3'd0,0), 101);
    apply(mk(1,0,4'hE,4'h0,2'b00,4'h5,0,4'h0,4'h0,3'd0, 4'h5,1,4'h0,0,3'd0,0), 102);

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard drain: got %0d entries want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cond_it_unit.md
# cond_it_unit

Parametrised conditional-execution unit for the ARM core. It holds the NZCV flag register with split write enables and gates NCTRL control strobes by the evaluated condition. It also adds an If-Then (IT) predication mode: one IT instruction predicates up to IT_DEPTH following instructions with a then/else mask. It sits between the decoder and the write-back/memory/PC-select strobes, and honours pipeline stall and flush.

## Interface
- IT_DEPTH, 4: maximum number of instructions an IT block may cover (≥1).
- NCTRL, 4: number of control strobes gated by the condition, e.g. RegW, MemW, PCS, branch.
- LW (localparam) = $clog2(IT_DEPTH+1): width of the length and count fields.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  the current instruction advances this cycle. 0 means stall.
- flush  in  1  aborts any active IT block.
- Cond  in  4  condition field of the current instruction.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- CtrlIn  in  NCTRL  ungated control strobes.
- it_start  in  1  the current instruction is an IT instruction.
- it_cond  in  4  firstcond of the IT instruction.
- it_mask  in  IT_DEPTH  bit i=1 means instruction i uses it_cond ("then"); 0 means it_cond^4'b0001 ("else").
- it_len  in  LW  number of instructions the block covers.
- CtrlOut  out  NCTRL  gated strobes.
- CondEx  out  1  the current instruction executes.
- Flags  out  4  registered NZCV.
- in_it  out  1  an IT block is active.
- it_remaining  out  LW  instructions left in the active block.
- it_err  out  1  one-cycle pulse on a rejected IT instruction.

## Operation
- **Effective condition:**
  - When in_it=1: it_cond_q if mask_q[0]=1, otherwise it_cond_q^1.
  - When in_it=0: Cond.
- **Evaluation:** against the registered Flags.
  - 0000 EQ … 1101 LE per standard ARM encoding.
  - 1110 AL gives 1.
  - 1111 gives 0. This is decided behaviour; there is no X.
- **Output gating:**
  - CtrlOut = CtrlIn & {NCTRL{CondEx & en}}.
  - CtrlOut is forced to 0 while reset is asserted.
- **Flag register:** the N,Z pair loads when en & FlagW[1] & CondEx; the C,V pair loads when en & FlagW[0] & CondEx.
- **IT acceptance:** requires en & it_start & CondEx & ~in_it & ~flush & (1 ≤ it_len ≤ IT_DEPTH). On acceptance:
  - it_cond_q←it_cond, mask_q←it_mask, count←it_len.
  - in_it=1 from the next cycle.
  - The IT instruction itself is gated by Cond like any other instruction.
- **IT rejection:** an IT instruction with en & it_start & ~flush fails if in_it=1 (nesting) or it_len is outside 1..IT_DEPTH. It then:
  - pulses it_err for that cycle;
  - forces CtrlOut=0;
  - leaves the IT state unchanged.
- **In-block advance:** each en cycle while in_it=1 sets mask_q←mask_q>>1 and count←count-1. When count reaches 0, in_it clears.
  - This applies whether or not the instruction executed.
  - An instruction with it_start=1 inside a block counts as nesting: it is rejected and the count still advances.
- **Stall:** en=0 holds all state. CondEx stays valid; CtrlOut=0.
- **Flush:** clears in_it, count and mask_q at the next edge. It has priority over en, it_start and advance. The instruction present in the flush cycle is still gated normally.
- it_remaining = count. in_it = (count≠0).

## Timing
- CondEx and CtrlOut are combinational from inputs and registered state; there are zero cycles of latency.
- Flag updates are visible to the instruction in the next en cycle, i.e. one cycle later.
- IT accepted at edge t: the first predicated instruction is evaluated in the cycle after t, using mask bit 0.
- Async reset values: Flags=0000, in_it=0, it_remaining=0, mask_q=0, it_cond_q=0, it_err=0, CtrlOut=0.
- Reset asserted mid-block abandons the block immediately. After deassertion, the unit starts out of IT mode.
- A last block instruction (count=1) stalled by en=0 keeps in_it=1 until it advances.

## Structure
- Package cond_pkg holds:
  - cond_e, the 16-entry condition enum;
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the AL/NV constants.
- One combinational sub-module, cond_eval (Cond, Flags → CondEx), instantiated once on the effective condition.
- The top level holds the flag register, the IT state registers and the gating logic, all as `always_ff` blocks with asynchronous active-low reset.

## Test plan
- Reset release, then Cond=1110, CtrlIn=4'b1111, en=1 → CtrlOut=1111, Flags=0000. Cond=0000 (EQ) with Z=0 → CtrlOut=0000.
- FlagW=11, ALUFlags=0100 (Z) at cycle t → Flags=0100 at t+1, and a Cond=0000 instruction at t+1 drives CtrlOut=CtrlIn. FlagW=01 with ALUFlags=1011 → Flags=0111.
- IT with it_cond=0000, it_mask=4'b0101, it_len=3, Z=1 → three following instructions give CondEx=1,0,1. in_it falls after the third; it_remaining steps 3,2,1,0.
- en=0 for 2 cycles mid-block → count and mask are held, CtrlOut=0. The block then resumes at the same mask bit.
- A second it_start while in_it=1 → it_err=1 for one cycle, CtrlOut=0, and the count still decrements. it_len=0 or 5 (with IT_DEPTH=4) → it_err=1 and no block starts.
- flush together with it_start → no block starts. flush at it_remaining=2 → in_it=0 next cycle. Reset pulse mid-block → all outputs return to their reset values asynchronously.
